// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that hands a shared up-counter to one requester at a time.
// Optional macro COUNTER_ARB_ABORT_EN lets the owner abandon its run by dropping req during RUN.
module counter_arbiter #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned CW   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [CW-1:0]   len0,
   input  logic [CW-1:0]   len1,
   output logic [NREQ-1:0] gnt,
   output logic            busy,
   output logic [CW-1:0]   count,
   output logic [NREQ-1:0] done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic            owner;
   logic            owner_nxt;
   logic            ptr;
   logic            ptr_nxt;
   logic [CW-1:0]   limit;
   logic [CW-1:0]   limit_nxt;
   logic [CW-1:0]   count_nxt;
   logic [NREQ-1:0] gnt_nxt;
   logic [NREQ-1:0] done_nxt;

   logic            win;
   logic            abort;
   logic            at_limit;

   function automatic logic [NREQ-1:0] onehot(input logic idx);
      onehot = NREQ'(1) << idx;
   endfunction

   // Round-robin pick: ptr breaks ties, a lone requester always wins.
   always_comb begin
      win = 1'b0;
      if (req[0] && req[1]) begin
         win = ptr;
      end else if (req[1]) begin
         win = 1'b1;
      end
   end

`ifdef COUNTER_ARB_ABORT_EN
   assign abort = ~req[owner];
`else
   assign abort = 1'b0;
`endif

   assign at_limit = (count == limit);
   assign busy     = (state == RUN) || (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort outranks reaching the limit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (at_limit) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for every registered output and datapath register.
   always_comb begin
      gnt_nxt   = gnt;
      done_nxt  = '0;
      count_nxt = count;
      limit_nxt = limit;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      case (state)
         IDLE: begin
            if (|req) begin
               owner_nxt = win;
               limit_nxt = win ? len1 : len0;
               count_nxt = '0;
               gnt_nxt   = onehot(win);
            end
         end
         RUN: begin
            if (abort) begin
               gnt_nxt   = '0;
               count_nxt = '0;
               ptr_nxt   = ~owner;
            end else if (at_limit) begin
               done_nxt  = onehot(owner);
            end else begin
               count_nxt = count + CW'(1);
            end
         end
         DONE: begin
            gnt_nxt = '0;
            ptr_nxt = ~owner;
         end
         default: begin
            gnt_nxt   = '0;
            count_nxt = '0;
         end
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt   <= '0;
         done  <= '0;
         count <= '0;
         limit <= '0;
         ptr   <= 1'b0;
         owner <= 1'b0;
      end else begin
         gnt   <= gnt_nxt;
         done  <= done_nxt;
         count <= count_nxt;
         limit <= limit_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
      end
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: reset, single run, contention, boundaries, reset mid-run,
// abort (expectations follow COUNTER_ARB_ABORT_EN) and length stability.
module tb_counter_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] req = 2'b00;
   logic [3:0] len0 = 4'd0;
   logic [3:0] len1 = 4'd0;
   logic [1:0] gnt;
   logic       busy;
   logic [3:0] count;
   logic [1:0] done;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   counter_arbiter #(.NREQ(2), .CW(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .len0  (len0),
      .len1  (len1),
      .gnt   (gnt),
      .busy  (busy),
      .count (count),
      .done  (done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      tick();
      tick();
      vectors++;
      if ({gnt, done, busy, count} !== {2'b00, 2'b00, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL reset_state: got gnt=%b done=%b busy=%b count=%0d, want 00 00 0 0",
                  gnt, done, busy, count);
      end
      rst = 1'b1;
      tick();
      vectors++;
      if ({gnt, busy} !== {2'b00, 1'b0}) begin
         errors++;
         $display("FAIL idle_no_req: got gnt=%b busy=%b, want 00 0", gnt, busy);
      end
   endtask

   task automatic test_single;
      len0 = 4'd3;
      req  = 2'b01;
      for (int i = 0; i <= 3; i++) begin
         tick();
         vectors++;
         if ({gnt, done, busy, count} !== {2'b01, 2'b00, 1'b1, 4'(i)}) begin
            errors++;
            $display("FAIL single_run[%0d]: got gnt=%b done=%b busy=%b count=%0d, want 01 00 1 %0d",
                     i, gnt, done, busy, count, i);
         end
      end
      tick();
      req = 2'b00;
      vectors++;
      if ({gnt, done, busy, count} !== {2'b01, 2'b01, 1'b1, 4'd3}) begin
         errors++;
         $display("FAIL single_done: got gnt=%b done=%b busy=%b count=%0d, want 01 01 1 3",
                  gnt, done, busy, count);
      end
      tick();
      vectors++;
      if ({gnt, done, busy, count} !== {2'b00, 2'b00, 1'b0, 4'd3}) begin
         errors++;
         $display("FAIL single_idle: got gnt=%b done=%b busy=%b count=%0d, want 00 00 0 3",
                  gnt, done, busy, count);
      end
   endtask

   // Rows are {gnt, done, busy, count} per cycle with req=11 held, ptr=0 after reset.
   task automatic test_contention;
      logic [8:0] exp_tab [14];
      exp_tab = '{9'b01_00_1_0000, 9'b01_00_1_0001, 9'b01_00_1_0010, 9'b01_01_1_0010,
                  9'b00_00_0_0010, 9'b10_00_1_0000, 9'b10_00_1_0001, 9'b10_10_1_0001,
                  9'b00_00_0_0001, 9'b01_00_1_0000, 9'b01_00_1_0001, 9'b01_00_1_0010,
                  9'b01_01_1_0010, 9'b00_00_0_0010};
      rst = 1'b0;
      tick();
      len0 = 4'd2;
      len1 = 4'd1;
      req  = 2'b11;
      rst  = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         vectors++;
         if ({gnt, done, busy, count} !== exp_tab[i]) begin
            errors++;
            $display("FAIL contention[%0d]: got %b_%b_%b_%b, want %b", i, gnt, done, busy, count,
                     exp_tab[i]);
         end
         if (i == 12) req = 2'b00;
      end
   endtask

   task automatic test_boundaries;
      len1 = 4'd0;
      req  = 2'b10;
      tick();
      vectors++;
      if ({gnt, done, busy, count} !== {2'b10, 2'b00, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL len_zero_run: got gnt=%b done=%b busy=%b count=%0d, want 10 00 1 0",
                  gnt, done, busy, count);
      end
      tick();
      req = 2'b00;
      vectors++;
      if ({gnt, done, count} !== {2'b10, 2'b10, 4'd0}) begin
         errors++;
         $display("FAIL len_zero_done: got gnt=%b done=%b count=%0d, want 10 10 0", gnt, done, count);
      end
      tick();
      len0 = 4'd15;
      req  = 2'b01;
      for (int i = 0; i <= 15; i++) begin
         tick();
         vectors++;
         if ({gnt, done, busy, count} !== {2'b01, 2'b00, 1'b1, 4'(i)}) begin
            errors++;
            $display("FAIL len_max_run[%0d]: got gnt=%b done=%b busy=%b count=%0d, want 01 00 1 %0d",
                     i, gnt, done, busy, count, i);
         end
      end
      tick();
      req = 2'b00;
      vectors++;
      if ({gnt, done, count} !== {2'b01, 2'b01, 4'd15}) begin
         errors++;
         $display("FAIL len_max_done: got gnt=%b done=%b count=%0d, want 01 01 15", gnt, done, count);
      end
      tick();
      vectors++;
      if ({gnt, busy, count} !== {2'b00, 1'b0, 4'd15}) begin
         errors++;
         $display("FAIL len_max_idle: got gnt=%b busy=%b count=%0d, want 00 0 15", gnt, busy, count);
      end
   endtask

   task automatic test_reset_mid_run;
      len0 = 4'd10;
      req  = 2'b01;
      for (int i = 0; i < 6; i++) tick();
      vectors++;
      if ({gnt, count} !== {2'b01, 4'd5}) begin
         errors++;
         $display("FAIL mid_run_pre: got gnt=%b count=%0d, want 01 5", gnt, count);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if ({gnt, done, busy, count} !== {2'b00, 2'b00, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL async_reset: got gnt=%b done=%b busy=%b count=%0d, want 00 00 0 0",
                  gnt, done, busy, count);
      end
      tick();
      req  = 2'b10;
      len1 = 4'd2;
      rst  = 1'b1;
      tick();
      vectors++;
      if ({gnt, done, busy, count} !== {2'b10, 2'b00, 1'b1, 4'd0}) begin
         errors++;
         $display("FAIL post_reset_grant: got gnt=%b done=%b busy=%b count=%0d, want 10 00 1 0",
                  gnt, done, busy, count);
      end
      tick();
      tick();
      tick();
      req = 2'b00;
      vectors++;
      if ({gnt, done, count} !== {2'b10, 2'b10, 4'd2}) begin
         errors++;
         $display("FAIL post_reset_done: got gnt=%b done=%b count=%0d, want 10 10 2", gnt, done, count);
      end
      tick();
   endtask

   task automatic test_abort;
      len0 = 4'd8;
      req  = 2'b01;
      for (int i = 0; i < 5; i++) tick();
      req = 2'b00;
      tick();
`ifdef COUNTER_ARB_ABORT_EN
      vectors++;
      if ({gnt, done, busy, count} !== {2'b00, 2'b00, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL abort_idle: got gnt=%b done=%b busy=%b count=%0d, want 00 00 0 0",
                  gnt, done, busy, count);
      end
      tick();
      vectors++;
      if ({gnt, done} !== {2'b00, 2'b00}) begin
         errors++;
         $display("FAIL abort_no_done: got gnt=%b done=%b, want 00 00", gnt, done);
      end
`else
      for (int i = 5; i <= 8; i++) begin
         vectors++;
         if ({gnt, done, count} !== {2'b01, 2'b00, 4'(i)}) begin
            errors++;
            $display("FAIL no_abort_run[%0d]: got gnt=%b done=%b count=%0d, want 01 00 %0d",
                     i, gnt, done, count, i);
         end
         tick();
      end
      vectors++;
      if ({gnt, done, count} !== {2'b01, 2'b01, 4'd8}) begin
         errors++;
         $display("FAIL no_abort_done: got gnt=%b done=%b count=%0d, want 01 01 8", gnt, done, count);
      end
      tick();
`endif
   endtask

   task automatic test_len_stable;
      len0 = 4'd5;
      req  = 2'b01;
      for (int i = 0; i <= 5; i++) begin
         tick();
         if (i == 2) len0 = 4'd1;
         vectors++;
         if ({gnt, done, count} !== {2'b01, 2'b00, 4'(i)}) begin
            errors++;
            $display("FAIL len_stable_run[%0d]: got gnt=%b done=%b count=%0d, want 01 00 %0d",
                     i, gnt, done, count, i);
         end
      end
      tick();
      req = 2'b00;
      vectors++;
      if ({gnt, done, count} !== {2'b01, 2'b01, 4'd5}) begin
         errors++;
         $display("FAIL len_stable_done: got gnt=%b done=%b count=%0d, want 01 01 5", gnt, done, count);
      end
      tick();
      vectors++;
      if ({gnt, busy} !== {2'b00, 1'b0}) begin
         errors++;
         $display("FAIL len_stable_idle: got gnt=%b busy=%b, want 00 0", gnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_boundaries();
      test_reset_mid_run();
      test_abort();
      test_len_stable();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 Parameter: NREQ, 2, number of requesters (fixed at 2; other values unsupported).
REQ-002 Parameter: CW, 4, counter/length width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 req  input  2  per-requester run request, level-sensitive.
REQ-006 len0  input  4  requester 0 terminal count, sampled at grant only.
REQ-007 len1  input  4  requester 1 terminal count, sampled at grant only.
REQ-008 gnt  output  2  one-hot grant to the owner of the shared counter; 0 when idle.
REQ-009 busy  output  1  high while in RUN or DONE.
REQ-010 count  output  4  shared counter value.
REQ-011 done  output  2  one-cycle completion pulse to the granted requester.

Function
REQ-012 FSM states IDLE, RUN, DONE; encoding free; no other reachable states.
REQ-013 IDLE: req sampled every cycle; if req!=0, winner chosen, limit<=len of winner, count<=0, gnt<=onehot(winner), next state RUN.
REQ-014 Arbitration round-robin: pointer ptr names the preferred requester; both requesting -> ptr wins; one requesting -> that one wins regardless of ptr.
REQ-015 RUN: count increments by 1 per cycle while count!=limit; when count==limit, next state DONE, count held.
REQ-016 Latency: gnt high first cycle after req sampled in IDLE; RUN lasts exactly limit+1 cycles (count 0..limit).
REQ-017 len=0: RUN lasts one cycle with count=0, then DONE.
REQ-018 len=15: count reaches 15, no wrap to 0; next state DONE.
REQ-019 DONE lasts one cycle: done[winner]=1, gnt unchanged, ptr<=other requester; next state IDLE with gnt<=0, count held at last value.
REQ-020 len0/len1 changes after grant have no effect on the current run.
REQ-021 req held high through DONE is treated as a new request in IDLE; round-robin guarantees the other requester wins if also requesting.
REQ-022 done and gnt never have more than one bit set; done only asserted in DONE.
REQ-023 busy = (state==RUN)||(state==DONE), combinational from state.

Reset
REQ-024 rst=0 forces immediately (asynchronously): state=IDLE, gnt=0, done=0, busy=0, count=0, limit=0, ptr=0.
REQ-025 Reset mid-RUN abandons the run with no done pulse; first grant after reset release follows REQ-013 with ptr=0.
REQ-026 rst deassertion takes effect at the next rising clk edge; req sampled at that edge is honoured.

Configuration
REQ-027 Macro COUNTER_ARB_ABORT_EN compiles in the abort feature.
REQ-028 With COUNTER_ARB_ABORT_EN defined: req[winner]=0 sampled in RUN -> next state IDLE, gnt<=0, count<=0, no done pulse, ptr<=other requester.
REQ-029 With COUNTER_ARB_ABORT_EN undefined: req ignored in RUN and DONE; every granted run completes with a done pulse.
REQ-030 Abort request sampled in the same cycle as count==limit: abort takes priority (no done pulse).

Verification
REQ-031 Single run: rst released, req=01, len0=3 -> gnt=01 for 5 cycles (RUN count 0,1,2,3 + DONE), done=01 once, then gnt=00, count=3.
REQ-032 Contention: req=11 held, len0=2, len1=1, ptr=0 -> grants alternate 01,10,01; done pulses 01 then 10; no gap longer than one IDLE cycle.
REQ-033 Boundaries: len1=0 -> one RUN cycle count=0 then done=10; len0=15 -> count 0..15, 16 RUN cycles, no wrap.
REQ-034 Reset mid-run: len0=10, rst=0 while count=5 -> gnt, done, busy, count all 0 immediately; no done pulse; next req=10 gets grant.
REQ-035 Abort (COUNTER_ARB_ABORT_EN defined): len0=8, req drops to 00 at count=4 -> IDLE next cycle, count=0, no done; same stimulus with macro undefined -> run completes to count=8, done=01.
REQ-036 Length stability: len0=5 at grant, changed to 1 at count=2 -> run still ends at count=5.
